ladybird_uart_controller: RTL and testbench

- Register-mapped UART peripheral for the ladybird bus.
- Packs received serial bytes into words, and unpacks written words into serial bytes. The word size is runtime-selectable at 1–4 bytes, little-endian.
- Provides STATUS/CTRL registers, sticky overrun error, and a level interrupt.
- Sits beside the core's data bus and drives the board UART pins.
- Reuses the existing ladybird_uart_receiver, ladybird_uart_transmitter and ladybird_fifo.

---
 rtl/ladybird_uart_pkg.sv | 44 ++++
 rtl/ladybird_fifo.sv | 74 +++++++
 rtl/ladybird_uart_packer.sv | 66 ++++++
 rtl/ladybird_uart_receiver.sv | 100 ++++++++++
 rtl/ladybird_uart_transmitter.sv | 74 +++++++
 rtl/ladybird_uart_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_ladybird_uart_controller.sv | 289 ++++++++++++++++++++++++++++
 7 files changed

// File: rtl/ladybird_uart_pkg.sv
// Shared definitions for the ladybird UART peripheral.
//   - register offsets (addr[3:2]) for DATA / STATUS / CTRL / CLEAR
//   - bit positions inside STATUS, CTRL and CLEAR
//   - ctrl_t: the CTRL register contents
//   - rx_state_t: receiver FSM states
package ladybird_uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_CLEAR  = 2'd3;

   localparam int ST_RX_NONEMPTY   = 0;
   localparam int ST_TX_FULL       = 1;
   localparam int ST_TX_IDLE       = 2;
   localparam int ST_OVERRUN       = 3;
   localparam int ST_RX_COUNT_LSB  = 8;

   localparam int CTRL_NBYTES_LSB     = 0;
   localparam int CTRL_IRQ_RX_EN      = 8;
   localparam int CTRL_IRQ_TX_IDLE_EN = 9;

   localparam int CLR_OVERRUN = 0;
   localparam int CLR_FLUSH   = 1;

   typedef struct packed {
      logic       irq_tx_idle_en;
      logic       irq_rx_en;
      logic [2:0] nbytes;
   } ctrl_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Word sizes of 1..4 bytes are the only legal CTRL.nbytes values.
   function automatic logic nbytes_legal(input logic [2:0] nb);
      return (nb != 3'd0) && (nb <= 3'd4);
   endfunction

endpackage

// File: rtl/ladybird_fifo.sv
// Synchronous FIFO with occupancy count.
//   push/wdata  : enqueue (ignored when full unless a pop happens in the same cycle)
//   pop         : dequeue head (ignored when empty)
//   flush       : empty the FIFO, wins over push/pop
//   rdata       : current head word
//   full/empty/count : occupancy
module ladybird_fifo #(
   parameter int DW = 32,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

   logic [DW-1:0] mem_q [1 << AW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign do_pop  = pop && (count_q != '0) && !flush;
   assign do_push = push && ((count_q != DEPTH) || do_pop) && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == DEPTH);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/ladybird_uart_packer.sv
// Packs received bytes into little-endian words of 1..4 bytes.
//   byte_valid/byte_data : incoming bytes
//   nbytes               : live CTRL.nbytes, sampled at each word start
//   flush                : drop the partial word and restart at lane 0
//   push/word            : one-cycle strobe, one cycle after the last byte
module ladybird_uart_packer (
   input  logic        clk,
   input  logic        nrst,
   input  logic        flush,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   input  logic [2:0]  nbytes,
   output logic        push,
   output logic [31:0] word
);

   logic [1:0]  cnt_q, cnt_d;
   logic [2:0]  nb_q, nb_d;
   logic [31:0] lanes_q, lanes_d;
   logic        push_q, push_d;
   logic [2:0]  nb_eff;

   // The word size is frozen when the first byte of a word lands.
   assign nb_eff = (cnt_q == 2'd0) ? nbytes : nb_q;

   always_comb begin
      cnt_d   = cnt_q;
      nb_d    = nb_q;
      lanes_d = lanes_q;
      push_d  = 1'b0;
      if (flush) begin
         cnt_d   = '0;
         lanes_d = '0;
      end else if (byte_valid) begin
         if (cnt_q == 2'd0) begin
            nb_d    = nbytes;
            lanes_d = '0;
         end
         lanes_d[8*cnt_q +: 8] = byte_data;
         if ({1'b0, cnt_q} == nb_eff - 3'd1) begin
            cnt_d  = '0;
            push_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q   <= '0;
         nb_q    <= 3'd1;
         lanes_q <= '0;
         push_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         nb_q    <= nb_d;
         lanes_q <= lanes_d;
         push_q  <= push_d;
      end
   end

   assign push = push_q;
   assign word = lanes_q;

endmodule

// File: rtl/ladybird_uart_receiver.sv
// 8N1 UART receiver. Samples each bit at its centre using a down-counting
// bit timer. Frames with a bad stop bit are dropped silently.
//   rxd        : serial input (asynchronous, synchronised here)
//   byte_valid : one-cycle strobe with byte_data
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge (start bit)
// RX_START | half-bit wait, re-check start bit is still low
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling stop bit; deliver byte if it is high
module ladybird_uart_receiver
   import ladybird_uart_pkg::*;
#(
   parameter logic [15:0] WTIME = 16'h364
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   rx_state_t   state_q, state_d;
   logic        rxd_meta_q, rxd_sync_q;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        valid_q, valid_d;
   logic        tc;

   assign tc = (timer_q == 16'd0);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= RX_IDLE;
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         timer_q    <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rxd_meta_q <= rxd;
         rxd_sync_q <= rxd_meta_q;
         timer_q    <= timer_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = tc ? timer_q : timer_q - 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rxd_sync_q) begin
               state_d = RX_START;
               timer_d = {1'b0, WTIME[15:1]} - 16'd1;
            end
         end
         RX_START: begin
            if (tc) begin
               if (!rxd_sync_q) begin
                  state_d = RX_DATA;
                  timer_d = WTIME - 16'd1;
                  bit_d   = '0;
               end else begin
                  state_d = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (tc) begin
               shift_d = {rxd_sync_q, shift_q[7:1]};
               timer_d = WTIME - 16'd1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (tc) begin
               valid_d = rxd_sync_q;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      byte_valid = valid_q;
      byte_data  = shift_q;
   end

endmodule

// File: rtl/ladybird_uart_transmitter.sv
// 8N1 UART transmitter with a down-counting bit timer.
//   in_valid/in_data/in_ready : byte handshake, accepted when both high
//   busy                      : a frame is being shifted out
//   txd                       : serial output, idles high (also during reset)
module ladybird_uart_transmitter #(
   parameter logic [15:0] WTIME = 16'h364
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       busy,
   output logic       txd
);

   logic        busy_q, busy_d;
   logic        txd_q, txd_d;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  bits_q, bits_d;
   logic [8:0]  shift_q, shift_d;

   // shift_q holds the remaining data bits followed by the stop bit;
   // bits_q counts how many of them are still to be driven.
   always_comb begin
      busy_d  = busy_q;
      txd_d   = txd_q;
      timer_d = timer_q;
      bits_d  = bits_q;
      shift_d = shift_q;
      if (!busy_q) begin
         if (in_valid) begin
            busy_d  = 1'b1;
            txd_d   = 1'b0;
            shift_d = {1'b1, in_data};
            bits_d  = 4'd9;
            timer_d = WTIME - 16'd1;
         end
      end else if (timer_q == 16'd0) begin
         if (bits_q == 4'd0) begin
            busy_d = 1'b0;
            txd_d  = 1'b1;
         end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bits_d  = bits_q - 4'd1;
            timer_d = WTIME - 16'd1;
         end
      end else begin
         timer_d = timer_q - 16'd1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         busy_q  <= 1'b0;
         txd_q   <= 1'b1;
         timer_q <= '0;
         bits_q  <= '0;
         shift_q <= '1;
      end else begin
         busy_q  <= busy_d;
         txd_q   <= txd_d;
         timer_q <= timer_d;
         bits_q  <= bits_d;
         shift_q <= shift_d;
      end
   end

   assign in_ready = !busy_q;
   assign busy     = busy_q;
   assign txd      = txd_q;

endmodule

// File: rtl/ladybird_uart_controller.sv
// Register-mapped UART peripheral on the ladybird bus.
//   clk, nrst          : clock, asynchronous active-low reset
//   uart_txd_in        : serial line from host (into our receiver)
//   uart_rxd_out       : serial line to host (from our transmitter)
//   req/addr/wstrb/wdata, gnt, rdata/data_gnt : bus port, wstrb==0 is a read
//   irq                : level interrupt, registered
// Registers (addr[3:2]): DATA, STATUS, CTRL, CLEAR.
module ladybird_uart_controller
   import ladybird_uart_pkg::*;
#(
   parameter logic [15:0] WTIME        = 16'h364,
   parameter int          FIFO_DEPTH_W = 3,
   parameter int          RESET_NBYTES = 1
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        uart_txd_in,
   output logic        uart_rxd_out,
   input  logic        req,
   input  logic [3:0]  addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        gnt,
   output logic [31:0] rdata,
   output logic        data_gnt,
   output logic        irq
);

   localparam ctrl_t CTRL_RESET = '{irq_tx_idle_en: 1'b0, irq_rx_en: 1'b0,
                                    nbytes: 3'(RESET_NBYTES)};

   ctrl_t       ctrl_q, ctrl_d;
   logic        overrun_q, overrun_d;
   logic        data_gnt_q, data_gnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q, irq_d;
   logic [1:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_nb_q, tx_nb_d;

   logic [1:0]  reg_sel;
   logic        rd_req, wr_req, rd_gnt, wr_gnt;
   logic        ctrl_wr, clr_wr, flush;
   logic        unused_addr;

   logic                  rx_byte_valid;
   logic [7:0]            rx_byte;
   logic                  rx_push, rx_pop, rx_full, rx_empty, rx_drop;
   logic [31:0]           rx_word, rx_head;
   logic [FIFO_DEPTH_W:0] rx_count;

   logic                  tx_push, tx_pop, tx_full, tx_empty;
   logic [31:0]           tx_head;
   logic [FIFO_DEPTH_W:0] tx_count_unused;
   logic                  tx_in_valid, tx_in_ready, tx_busy, tx_accept, tx_last;
   logic [2:0]            tx_nb_eff;
   logic                  tx_idle;

   logic [31:0] status_word, ctrl_word;

   assign unused_addr = ^addr[1:0];

   // ---------------- bus decode ----------------
   assign reg_sel = addr[3:2];
   assign rd_req  = req && (wstrb == 4'b0000);
   assign wr_req  = req && (wstrb != 4'b0000);
   // data_gnt_q high means the single allowed read is still in flight.
   assign rd_gnt  = rd_req && !data_gnt_q;
   assign wr_gnt  = wr_req && ((reg_sel != REG_DATA) || !tx_full);
   assign gnt     = rd_gnt || wr_gnt;

   assign ctrl_wr = wr_gnt && (reg_sel == REG_CTRL);
   assign clr_wr  = wr_gnt && (reg_sel == REG_CLEAR) && wstrb[0];
   assign flush   = clr_wr && wdata[CLR_FLUSH];

   assign rx_pop  = rd_gnt && (reg_sel == REG_DATA) && !rx_empty;
   assign tx_push = wr_gnt && (reg_sel == REG_DATA);

   // ---------------- RX path ----------------
   ladybird_uart_receiver #(.WTIME(WTIME)) u_rx (
      .clk        (clk),
      .nrst       (nrst),
      .rxd        (uart_txd_in),
      .byte_valid (rx_byte_valid),
      .byte_data  (rx_byte)
   );

   ladybird_uart_packer u_packer (
      .clk        (clk),
      .nrst       (nrst),
      .flush      (flush),
      .byte_valid (rx_byte_valid),
      .byte_data  (rx_byte),
      .nbytes     (ctrl_q.nbytes),
      .push       (rx_push),
      .word       (rx_word)
   );

   ladybird_fifo #(.DW(32), .AW(FIFO_DEPTH_W)) u_rx_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (rx_push),
      .pop   (rx_pop),
      .flush (flush),
      .wdata (rx_word),
      .rdata (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // A pop in the same cycle frees the slot, so only a full FIFO without a
   // concurrent read loses the word.
   assign rx_drop = rx_push && rx_full && !rx_pop;

   // ---------------- TX path ----------------
   ladybird_fifo #(.DW(32), .AW(FIFO_DEPTH_W)) u_tx_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (tx_push),
      .pop   (tx_pop),
      .flush (flush),
      .wdata (wdata),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count_unused)
   );

   assign tx_nb_eff   = (tx_cnt_q == 2'd0) ? ctrl_q.nbytes : tx_nb_q;
   assign tx_in_valid = !tx_empty && !flush;
   assign tx_accept   = tx_in_valid && tx_in_ready;
   assign tx_last     = ({1'b0, tx_cnt_q} == tx_nb_eff - 3'd1);
   assign tx_pop      = tx_accept && tx_last;

   ladybird_uart_transmitter #(.WTIME(WTIME)) u_tx (
      .clk      (clk),
      .nrst     (nrst),
      .in_valid (tx_in_valid),
      .in_data  (tx_head[8*tx_cnt_q +: 8]),
      .in_ready (tx_in_ready),
      .busy     (tx_busy),
      .txd      (uart_rxd_out)
   );

   assign tx_idle = tx_empty && !tx_busy;

   always_comb begin
      tx_cnt_d = tx_cnt_q;
      tx_nb_d  = tx_nb_q;
      if (flush) begin
         tx_cnt_d = '0;
      end else if (tx_accept) begin
         if (tx_cnt_q == 2'd0) tx_nb_d = ctrl_q.nbytes;
         tx_cnt_d = tx_last ? 2'd0 : tx_cnt_q + 2'd1;
      end
   end

   // ---------------- registers ----------------
   always_comb begin
      status_word                             = '0;
      status_word[ST_RX_NONEMPTY]             = !rx_empty;
      status_word[ST_TX_FULL]                 = tx_full;
      status_word[ST_TX_IDLE]                 = tx_idle;
      status_word[ST_OVERRUN]                 = overrun_q;
      status_word[ST_RX_COUNT_LSB +: 8]       = 8'(rx_count);

      ctrl_word                               = '0;
      ctrl_word[CTRL_NBYTES_LSB +: 3]         = ctrl_q.nbytes;
      ctrl_word[CTRL_IRQ_RX_EN]               = ctrl_q.irq_rx_en;
      ctrl_word[CTRL_IRQ_TX_IDLE_EN]          = ctrl_q.irq_tx_idle_en;
   end

   always_comb begin
      ctrl_d     = ctrl_q;
      overrun_d  = overrun_q;
      data_gnt_d = rd_gnt;
      rdata_d    = '0;

      if (rd_gnt) begin
         case (reg_sel)
            REG_DATA:   rdata_d = rx_empty ? 32'h0 : rx_head;
            REG_STATUS: rdata_d = status_word;
            REG_CTRL:   rdata_d = ctrl_word;
            default:    rdata_d = 32'h0;
         endcase
      end

      if (ctrl_wr) begin
         if (wstrb[0] && nbytes_legal(wdata[CTRL_NBYTES_LSB +: 3]))
            ctrl_d.nbytes = wdata[CTRL_NBYTES_LSB +: 3];
         if (wstrb[1]) begin
            ctrl_d.irq_rx_en      = wdata[CTRL_IRQ_RX_EN];
            ctrl_d.irq_tx_idle_en = wdata[CTRL_IRQ_TX_IDLE_EN];
         end
      end

      // A new overrun in the clearing cycle must not be lost.
      if (clr_wr && wdata[CLR_OVERRUN]) overrun_d = 1'b0;
      if (rx_drop)                      overrun_d = 1'b1;

      irq_d = (ctrl_q.irq_rx_en && !rx_empty) || (ctrl_q.irq_tx_idle_en && tx_idle);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ctrl_q     <= CTRL_RESET;
         overrun_q  <= 1'b0;
         data_gnt_q <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
         tx_cnt_q   <= '0;
         tx_nb_q    <= 3'(RESET_NBYTES);
      end else begin
         ctrl_q     <= ctrl_d;
         overrun_q  <= overrun_d;
         data_gnt_q <= data_gnt_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_nb_q    <= tx_nb_d;
      end
   end

   assign rdata    = rdata_q;
   assign data_gnt = data_gnt_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_ladybird_uart_controller.sv
// Directed bench for ladybird_uart_controller with a short bit time.
module tb_ladybird_uart_controller;

   localparam int WT = 16;

   logic        clk = 1'b0;
   logic        nrst;
   logic        uart_txd_in;
   logic        uart_rxd_out;
   logic        req;
   logic [3:0]  addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        gnt;
   logic [31:0] rdata;
   logic        data_gnt;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   ladybird_uart_controller #(
      .WTIME        (16'(WT)),
      .FIFO_DEPTH_W (3),
      .RESET_NBYTES (1)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .uart_txd_in  (uart_txd_in),
      .uart_rxd_out (uart_rxd_out),
      .req          (req),
      .addr         (addr),
      .wstrb        (wstrb),
      .wdata        (wdata),
      .gnt          (gnt),
      .rdata        (rdata),
      .data_gnt     (data_gnt),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   typedef struct packed {
      logic        is_wr;
      logic [3:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait expired, required the event to occur", name);
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      int cyc = 0;
      d = 32'hDEAD_BEEF;
      @(negedge clk);
      req = 1'b1; addr = a; wstrb = 4'h0; wdata = 32'h0;
      #1;
      while (!gnt && cyc < 50) begin
         @(negedge clk); #1; cyc++;
      end
      if (!gnt) begin
         req = 1'b0;
         timeout_fail("read gnt");
         return;
      end
      @(negedge clk);
      req = 1'b0;
      #1;
      chk("read data_gnt one cycle after gnt", {31'b0, data_gnt}, 32'd1);
      d = rdata;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      int cyc = 0;
      @(negedge clk);
      req = 1'b1; addr = a; wstrb = 4'hF; wdata = d;
      #1;
      while (!gnt && cyc < 50) begin
         @(negedge clk); #1; cyc++;
      end
      if (!gnt) begin
         req = 1'b0;
         timeout_fail("write gnt");
         return;
      end
      @(negedge clk);
      req = 1'b0;
      #1;
      chk("write returns no data_gnt", {31'b0, data_gnt}, 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_txd_in = frame[i];
         repeat (WT - 1) @(negedge clk);
      end
   endtask

   task automatic recv_byte(output logic [7:0] b);
      int cyc = 0;
      b = 8'h00;
      while (uart_rxd_out !== 1'b0 && cyc < 4000) begin
         @(negedge clk); cyc++;
      end
      if (uart_rxd_out !== 1'b0) begin
         timeout_fail("line start bit");
         return;
      end
      repeat (WT/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         repeat (WT) @(negedge clk);
         b[i] = uart_rxd_out;
      end
      repeat (WT) @(negedge clk);
      chk("line stop bit", {31'b0, uart_rxd_out}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  rb;
      int          stall;
      int          cyc;

      vecs[0]  = '{1'b0, 4'h4, 32'h0,   32'h0000_0004};
      vecs[1]  = '{1'b0, 4'h8, 32'h0,   32'h0000_0001};
      vecs[2]  = '{1'b0, 4'h0, 32'h0,   32'h0000_0000};
      vecs[3]  = '{1'b0, 4'hC, 32'h0,   32'h0000_0000};
      vecs[4]  = '{1'b1, 4'h8, 32'h0,   32'h0};
      vecs[5]  = '{1'b0, 4'h8, 32'h0,   32'h0000_0001};
      vecs[6]  = '{1'b1, 4'h8, 32'h7,   32'h0};
      vecs[7]  = '{1'b0, 4'h8, 32'h0,   32'h0000_0001};
      vecs[8]  = '{1'b1, 4'h8, 32'h303, 32'h0};
      vecs[9]  = '{1'b0, 4'h8, 32'h0,   32'h0000_0303};
      vecs[10] = '{1'b1, 4'h8, 32'h003, 32'h0};
      vecs[11] = '{1'b0, 4'h8, 32'h0,   32'h0000_0003};
      vecs[12] = '{1'b1, 4'h8, 32'h001, 32'h0};
      vecs[13] = '{1'b0, 4'h8, 32'h0,   32'h0000_0001};
      vecs[14] = '{1'b0, 4'h4, 32'h0,   32'h0000_0004};

      nrst = 1'b0; uart_txd_in = 1'b1;
      req = 1'b0; addr = 4'h0; wstrb = 4'h0; wdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset gnt", {31'b0, gnt}, 32'd0);
      chk("reset data_gnt", {31'b0, data_gnt}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
      chk("reset irq", {31'b0, irq}, 32'd0);
      chk("reset uart_rxd_out", {31'b0, uart_rxd_out}, 32'd1);
      @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      // register map vectors
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].is_wr) begin
            bus_write(vecs[i].a, vecs[i].d);
         end else begin
            bus_read(vecs[i].a, rd);
            chk($sformatf("vec[%0d] read", i), rd, vecs[i].exp);
         end
      end

      // nbytes=1: two bytes become two words
      send_byte(8'h41);
      send_byte(8'h42);
      bus_read(4'h0, rd);
      chk("rx word 0x41", rd, 32'h0000_0041);
      bus_read(4'h0, rd);
      chk("rx word 0x42", rd, 32'h0000_0042);

      // nbytes=4: a word appears only after the fourth byte
      bus_write(4'h8, 32'h4);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      bus_read(4'h4, rd);
      chk("status after 3 of 4 bytes", rd, 32'h0000_0004);
      send_byte(8'h44);
      bus_read(4'h4, rd);
      chk("status after 4 of 4 bytes", rd, 32'h0000_0105);
      bus_read(4'h0, rd);
      chk("rx 4-byte word", rd, 32'h4433_2211);

      // nbytes=2 transmit with tx-idle interrupt
      bus_write(4'h8, 32'h202);
      repeat (2) @(negedge clk);
      #1;
      chk("irq while tx idle", {31'b0, irq}, 32'd1);
      bus_write(4'h0, 32'hAABB_CCDD);
      recv_byte(rb);
      chk("tx byte 0", {24'b0, rb}, 32'h0000_00DD);
      chk("irq low while shifting", {31'b0, irq}, 32'd0);
      recv_byte(rb);
      chk("tx byte 1", {24'b0, rb}, 32'h0000_00CC);
      chk("irq low during last stop bit", {31'b0, irq}, 32'd0);
      cyc = 0;
      while (!irq && cyc < 3*WT) begin
         @(negedge clk); cyc++;
      end
      if (!irq) timeout_fail("irq after tx idle");
      else      chk("irq rise delay within stop half-bit", {31'b0, (cyc <= WT/2 + 2)}, 32'd1);
      bus_read(4'h4, rd);
      chk("status tx idle after 2-byte word", rd, 32'h0000_0004);
      bus_write(4'h8, 32'h001);

      // TX FIFO full: ninth queued word stalls until the first word finishes
      for (int i = 0; i < 9; i++) bus_write(4'h0, 32'h100 + i);
      @(negedge clk);
      req = 1'b1; addr = 4'h0; wstrb = 4'hF; wdata = 32'h0000_00A5;
      #1;
      chk("write to full tx fifo stalls", {31'b0, gnt}, 32'd0);
      stall = 0;
      while (!gnt && stall < 400) begin
         @(negedge clk); #1; stall++;
      end
      if (!gnt) timeout_fail("stalled write gnt");
      else      chk("stall length about one frame", {31'b0, (stall >= 120 && stall <= 175)}, 32'd1);
      @(negedge clk);
      #1;
      chk("gnt only one cycle", {31'b0, gnt}, 32'd0);
      req = 1'b0;
      rd = 32'h0;
      for (int i = 0; i < 100; i++) begin
         bus_read(4'h4, rd);
         if (rd[2]) break;
         repeat (50) @(negedge clk);
      end
      chk("tx drained", rd, 32'h0000_0004);

      // overrun: nine bytes into an eight-entry FIFO
      for (int i = 1; i <= 9; i++) send_byte(8'(i));
      repeat (4) @(negedge clk);
      bus_read(4'h4, rd);
      chk("status overrun full", rd, 32'h0000_080D);
      for (int i = 1; i <= 8; i++) begin
         bus_read(4'h0, rd);
         chk($sformatf("overrun read %0d", i), rd, 32'(i));
      end
      bus_read(4'h4, rd);
      chk("status overrun empty", rd, 32'h0000_000C);
      bus_write(4'hC, 32'h1);
      bus_read(4'h4, rd);
      chk("status after clear", rd, 32'h0000_0004);
      bus_read(4'h0, rd);
      chk("empty data read", rd, 32'h0);

      // reset in the middle of a byte
      bus_write(4'h0, 32'h55);
      repeat (2*WT + 4) @(negedge clk);
      chk("line low mid byte", {31'b0, uart_rxd_out}, 32'd0);
      nrst = 1'b0;
      #1;
      chk("line idle at reset", {31'b0, uart_rxd_out}, 32'd1);
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      bus_read(4'h4, rd);
      chk("status after reset", rd, 32'h0000_0004);
      bus_read(4'h8, rd);
      chk("ctrl after reset", rd, 32'h0000_0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
